vga_timing_gen: RTL

Produces the VGA raster timing that the pixel pattern logic consumes: pixel column/row coordinates, a visible-area flag, and hsync/vsync.
- Also emits one-cycle line_start and frame_start strobes, so downstream logic stops decoding (col==0 && row==0) itself.
- Runs on the 25.175 MHz pixel clock; default timing is 640x480 @ 60 Hz.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_axis_counter.sv | 65 ++++++
 rtl/vga_timing_gen.sv | 115 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA raster definitions: default 640x480@60 timing, coordinate width
// and the per-axis phase encoding used by the timing generator and pattern logic.
package vga_pkg;

  localparam int COORD_W   = 10;
  localparam int MAX_TOTAL = 1 << COORD_W;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_t;

  // Phase entered after the current one ends; zero-width phases are skipped.
  function automatic phase_t next_phase(input phase_t cur, input int fp,
                                        input int sync, input int bp);
    phase_t nxt;
    nxt = PH_ACTIVE;
    if (cur == PH_ACTIVE && fp > 0)
      nxt = PH_FRONT;
    else if ((cur == PH_ACTIVE || cur == PH_FRONT) && sync > 0)
      nxt = PH_SYNC;
    else if (cur != PH_BACK && bp > 0)
      nxt = PH_BACK;
    return nxt;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Counter and FSM only move on cycles where advance is high.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FP      = DEF_H_FP,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BP      = DEF_H_BP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               advance,
  output logic [COORD_W-1:0] count,
  output logic [1:0]         phase,
  output logic               wrap
);

  localparam int TOTAL = VISIBLE + FP + SYNC + BP;

  localparam logic [COORD_W-1:0] END_ACTIVE = COORD_W'(VISIBLE - 1);
  localparam logic [COORD_W-1:0] END_FRONT  = COORD_W'(VISIBLE + FP - 1);
  localparam logic [COORD_W-1:0] END_SYNC   = COORD_W'(VISIBLE + FP + SYNC - 1);
  localparam logic [COORD_W-1:0] END_BACK   = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] ONE        = COORD_W'(1);

  localparam phase_t AFTER_ACTIVE = next_phase(PH_ACTIVE, FP, SYNC, BP);
  localparam phase_t AFTER_FRONT  = next_phase(PH_FRONT, FP, SYNC, BP);
  localparam phase_t AFTER_SYNC   = next_phase(PH_SYNC, FP, SYNC, BP);

  logic [COORD_W-1:0] count_q;
  logic [COORD_W-1:0] count_d;
  phase_t             phase_q;
  phase_t             phase_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      phase_q <= PH_ACTIVE;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (advance) begin
      count_d = (count_q == END_BACK) ? '0 : count_q + ONE;
      unique case (phase_q)
        PH_ACTIVE: if (count_q == END_ACTIVE) phase_d = AFTER_ACTIVE;
        PH_FRONT:  if (count_q == END_FRONT)  phase_d = AFTER_FRONT;
        PH_SYNC:   if (count_q == END_SYNC)   phase_d = AFTER_SYNC;
        PH_BACK:   if (count_q == END_BACK)   phase_d = PH_ACTIVE;
        default:   phase_d = PH_ACTIVE;
      endcase
    end
  end

  assign count = count_q;
  assign phase = phase_q;
  assign wrap  = advance && (count_q == END_BACK);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: registered pixel coordinates, visible flag,
// sync pulses and line/frame start strobes, all aligned to the same pixel.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE       = DEF_H_VISIBLE,
  parameter int H_FP            = DEF_H_FP,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BP            = DEF_H_BP,
  parameter int V_VISIBLE       = DEF_V_VISIBLE,
  parameter int V_FP            = DEF_V_FP,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BP            = DEF_V_BP,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               visible,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic SYNC_OFF = ~SYNC_ON;

  if (H_TOTAL > MAX_TOTAL) begin : g_h_total_err
    $error("vga_timing_gen: H_TOTAL=%0d exceeds %0d", H_TOTAL, MAX_TOTAL);
  end
  if (V_TOTAL > MAX_TOTAL) begin : g_v_total_err
    $error("vga_timing_gen: V_TOTAL=%0d exceeds %0d", V_TOTAL, MAX_TOTAL);
  end

  logic [COORD_W-1:0] h_count;
  logic [COORD_W-1:0] v_count;
  logic [1:0]         h_phase;
  logic [1:0]         v_phase;
  logic               h_wrap;
  logic               v_wrap;
  logic               at_origin;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FP      (H_FP),
    .SYNC    (H_SYNC),
    .BP      (H_BP)
  ) u_h_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (1'b1),
    .count   (h_count),
    .phase   (h_phase),
    .wrap    (h_wrap)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FP      (V_FP),
    .SYNC    (V_SYNC),
    .BP      (V_BP)
  ) u_v_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (h_wrap),
    .count   (v_count),
    .phase   (v_phase),
    .wrap    (v_wrap)
  );

  logic [COORD_W-1:0] col_p1;
  logic [COORD_W-1:0] row_p1;
  logic               visible_p1;
  logic               hsync_p1;
  logic               vsync_p1;
  logic               line_start_p1;
  logic               frame_start_p1;

  // p0 -> p1: counters/phases registered into the output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_p1         <= '0;
      row_p1         <= '0;
      visible_p1     <= 1'b0;
      hsync_p1       <= SYNC_OFF;
      vsync_p1       <= SYNC_OFF;
      line_start_p1  <= 1'b0;
      frame_start_p1 <= 1'b0;
      at_origin      <= 1'b1;
    end else begin
      col_p1         <= h_count;
      row_p1         <= v_count;
      visible_p1     <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
      hsync_p1       <= (h_phase == PH_SYNC) ? SYNC_ON : SYNC_OFF;
      vsync_p1       <= (v_phase == PH_SYNC) ? SYNC_ON : SYNC_OFF;
      line_start_p1  <= (h_count == '0);
      frame_start_p1 <= at_origin;
      at_origin      <= v_wrap;
    end
  end

  assign col         = col_p1;
  assign row         = row_p1;
  assign visible     = visible_p1;
  assign hsync       = hsync_p1;
  assign vsync       = vsync_p1;
  assign line_start  = line_start_p1;
  assign frame_start = frame_start_p1;

endmodule
